// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_pkg
// Purpose  : Shared constants and slot record for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
package inst_fetch_pkg;

    localparam int          IFQ_DEPTH = 4;
    // Decode treats this word as a bubble, so it is what leaves when nothing is valid.
    localparam logic [31:0] NOP_INST  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_if
// Purpose  : Instruction-memory read bus: request handshake and in-order response.
// Revision : 1.0
// ============================================================================
interface inst_fetch_if;

    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );

endinterface
`default_nettype wire

// File: rtl/fetch_slots.sv
`default_nettype none
// ============================================================================
// Module   : fetch_slots
// Purpose  : Circular slot store with head/tail/fill pointers for fetch tracking.
// Revision : 1.0
// ============================================================================
module fetch_slots
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_alloc,
    input  wire logic [31:0]      i_alloc_pc,
    input  wire logic             i_fill,
    input  wire logic [31:0]      i_fill_data,
    input  wire logic             i_pop,
    input  wire logic             i_clear,
    output      logic [PTR_W:0]   o_count,
    output      logic [PTR_W:0]   o_unfilled,
    output      logic             o_head_filled,
    output      slot_t            o_head
);

    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] r_fill_ptr;
    logic [PTR_W:0]   r_count;
    logic [PTR_W:0]   r_unfilled;

    logic [PTR_W:0]   w_alloc_inc;
    logic [PTR_W:0]   w_fill_dec;
    logic [PTR_W:0]   w_pop_dec;

    assign w_alloc_inc = (PTR_W+1)'(i_alloc);
    assign w_fill_dec  = (PTR_W+1)'(i_fill);
    assign w_pop_dec   = (PTR_W+1)'(i_pop);

    // Responses return in issue order, so the oldest unfilled slot is always
    // the one at r_fill_ptr; it trails tail by exactly r_unfilled entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filled   <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_fill_ptr <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
        end else if (i_clear) begin
            r_filled   <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_fill_ptr <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
        end else begin
            if (i_alloc) begin
                r_tail <= r_tail + 1'b1;
            end
            if (i_fill) begin
                r_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + 1'b1;
            end
            if (i_pop) begin
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + 1'b1;
            end
            r_count    <= r_count + w_alloc_inc - w_pop_dec;
            r_unfilled <= r_unfilled + w_alloc_inc - w_fill_dec;
        end
    end

    // Payload storage needs no reset: r_filled and r_count gate every read.
    always_ff @(posedge clk) begin
        if (i_alloc && !i_clear) begin
            r_pc[r_tail] <= i_alloc_pc;
        end
        if (i_fill && !i_clear) begin
            r_data[r_fill_ptr] <= i_fill_data;
        end
    end

    assign o_count       = r_count;
    assign o_unfilled    = r_unfilled;
    assign o_head_filled = r_filled[r_head];
    assign o_head        = '{pc: r_pc[r_head], data: r_data[r_head]};

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Fetch stage: credit-limited imem issue, in-order response buffering,
//            flush with drop accounting for in-flight reads.
// Revision : 1.0
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        pc_valid,
    input  wire logic [31:0] pc_addr,
    output      logic        pc_ready,
    input  wire logic        flush,
    inst_fetch_if.master     mem,
    output      logic        inst_valid,
    output      logic [31:0] inst_data,
    output      logic [31:0] inst_pc,
    input  wire logic        inst_ready
);

    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0] r_drop_cnt;
    logic [PTR_W:0] w_drop_next;
    logic [PTR_W:0] w_count;
    logic [PTR_W:0] w_unfilled;
    logic [PTR_W:0] w_outstanding;
    logic [PTR_W:0] w_flush_pending;
    logic           w_credit;
    logic           w_issue_ok;
    logic           w_alloc;
    logic           w_fill;
    logic           w_pop;
    logic           w_drop_resp;
    logic           w_head_filled;
    slot_t          w_head;

    // Buffered slots plus reads still owed to a flush share the DEPTH budget,
    // so count + drop never exceeds DEPTH and PTR_W+1 bits always suffice.
    assign w_outstanding = w_count + r_drop_cnt;
    assign w_credit      = (w_outstanding < c_depth);
    assign w_issue_ok    = rst_n & w_credit & ~flush;

    assign mem.mem_req_valid = pc_valid & w_issue_ok;
    assign mem.mem_req_addr  = pc_addr;
    assign pc_ready          = mem.mem_req_ready & w_issue_ok;

    assign w_alloc     = pc_valid & pc_ready;
    assign w_drop_resp = mem.mem_resp_valid & (r_drop_cnt != '0);
    assign w_fill      = mem.mem_resp_valid & (r_drop_cnt == '0) & (w_unfilled != '0) & ~flush;

    assign inst_valid = (w_count != '0) & w_head_filled;
    assign inst_data  = inst_valid ? w_head.data : NOP_INST;
    assign inst_pc    = inst_valid ? w_head.pc   : 32'h0;
    assign w_pop      = inst_valid & inst_ready & ~flush;

    // On flush every unfilled slot becomes a read to discard; a response landing
    // in that same cycle retires one of those owed reads immediately.
    assign w_flush_pending = r_drop_cnt + w_unfilled;

    always_comb begin
        w_drop_next = r_drop_cnt;
        if (flush) begin
            if (mem.mem_resp_valid && (w_flush_pending != '0)) begin
                w_drop_next = w_flush_pending - 1'b1;
            end else begin
                w_drop_next = w_flush_pending;
            end
        end else if (w_drop_resp) begin
            w_drop_next = r_drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_next;
        end
    end

    fetch_slots #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_slots (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_alloc       (w_alloc),
        .i_alloc_pc    (pc_addr),
        .i_fill        (w_fill),
        .i_fill_data   (mem.mem_resp_data),
        .i_pop         (w_pop),
        .i_clear       (flush),
        .o_count       (w_count),
        .o_unfilled    (w_unfilled),
        .o_head_filled (w_head_filled),
        .o_head        (w_head)
    );

    // A response with nothing outstanding cannot be attributed to any fetch.
    a_resp_attributed : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(mem.mem_resp_valid && (r_drop_cnt == '0) && (w_unfilled == '0))
    );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Randomised and directed bench for inst_fetch against a queue model.
// Revision : 1.0
// ============================================================================
module tb_inst_fetch;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          filled;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc_addr = 32'h0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    inst_fetch_if mem_bus ();

    inst_fetch #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_valid   (pc_valid),
        .pc_addr    (pc_addr),
        .pc_ready   (pc_ready),
        .flush      (flush),
        .mem        (mem_bus.master),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    ent_t        q[$];
    req_t        pend[$];
    int          drop = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat = 1;
    int          issued = 0;
    logic [31:0] next_pc = 32'h0;
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_data[$];
    int          dlv_cyc[$];
    bit          last_rv;
    bit          last_mrv;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h20080005 + (a - 32'h10) * 32'h00010001;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        q.delete();
        pend.delete();
        drop     = 0;
        last_due = cyc;
    endtask

    // One clock: called just after a negedge with stimulus already set.
    task automatic step();
        bit          rv;
        bit          credit;
        bit          e_iv;
        bit          e_mrv;
        bit          e_pcr;
        bit          fire;
        bit          pop;
        logic [31:0] rd;
        int          u;
        int          due;
        rv = 1'b0;
        rd = 32'hDEAD_BEEF;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rv = 1'b1;
            rd = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
        mem_bus.mem_resp_valid = rv;
        mem_bus.mem_resp_data  = rd;
        pc_addr = next_pc;
        #2;
        credit = (q.size() + drop) < DEPTH;
        e_mrv  = pc_valid && credit && !flush;
        e_pcr  = mem_bus.mem_req_ready && credit && !flush;
        e_iv   = (q.size() > 0) && q[0].filled;
        check("pc_ready", {31'h0, pc_ready}, {31'h0, e_pcr});
        check("mem_req_valid", {31'h0, mem_bus.mem_req_valid}, {31'h0, e_mrv});
        if (e_mrv) check("mem_req_addr", mem_bus.mem_req_addr, pc_addr);
        check("inst_valid", {31'h0, inst_valid}, {31'h0, e_iv});
        check("inst_pc", inst_pc, e_iv ? q[0].pc : 32'h0);
        check("inst_data", inst_data, e_iv ? q[0].data : 32'h0);
        last_rv  = rv;
        last_mrv = e_mrv;
        fire = pc_valid && e_pcr;
        pop  = e_iv && inst_ready && !flush;
        if (flush) begin
            u = 0;
            foreach (q[i]) if (!q[i].filled) u++;
            drop = drop + u;
            if (rv && drop > 0) drop--;
            q.delete();
        end else begin
            if (pop) begin
                dlv_pc.push_back(q[0].pc);
                dlv_data.push_back(q[0].data);
                dlv_cyc.push_back(cyc);
                void'(q.pop_front());
            end
            if (rv) begin
                if (drop > 0) begin
                    drop--;
                end else begin
                    for (int i = 0; i < q.size(); i++) begin
                        if (!q[i].filled) begin
                            q[i].data   = rd;
                            q[i].filled = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (fire) begin
                q.push_back('{pc: pc_addr, data: 32'h0, filled: 1'b0});
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: pc_addr, due: due});
                next_pc = next_pc + 1;
                issued++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_deliver(input int n, input int budget);
        int k;
        k = 0;
        while (dlv_pc.size() < n && k < budget) begin
            step();
            k++;
        end
        if (dlv_pc.size() < n) check("deliver_timeout", dlv_pc.size(), n);
    endtask

    task automatic idle_drain(input int n);
        pc_valid   = 1'b0;
        flush      = 1'b0;
        inst_ready = 1'b1;
        mem_bus.mem_req_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int c0;
        mem_bus.mem_req_ready  = 1'b1;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_data  = 32'h0;
        pc_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pc_ready", {31'h0, pc_ready}, 32'h0);
        check("rst_req_valid", {31'h0, mem_bus.mem_req_valid}, 32'h0);
        check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        rst_n    = 1'b1;
        pc_valid = 1'b0;
        model_clear();

        // Two filled slots, then reset mid-operation.
        lat = 1; inst_ready = 1'b0; next_pc = 32'h80;
        pc_valid = 1'b1; repeat (2) step();
        pc_valid = 1'b0; repeat (2) step();
        check("pre_rst_buffered", q.size(), 2);
        rst_n = 1'b0; pc_valid = 1'b1;
        mem_bus.mem_resp_valid = 1'b0;
        #1;
        check("mid_rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("mid_rst_pc_ready", {31'h0, pc_ready}, 32'h0);
        check("mid_rst_inst_pc", inst_pc, 32'h0);
        model_clear();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; pc_valid = 1'b0;

        // Single fetch of 0x10 after reset.
        dlv_pc.delete(); dlv_data.delete(); dlv_cyc.delete();
        next_pc = 32'h10; inst_ready = 1'b1;
        pc_valid = 1'b1; step();
        pc_valid = 1'b0;
        wait_deliver(1, 8);
        check("first_fetch_pc", dlv_pc.size() > 0 ? dlv_pc[0] : 32'hFFFF_FFFF, 32'h10);
        check("first_fetch_data", dlv_data.size() > 0 ? dlv_data[0] : 32'hFFFF_FFFF, 32'h20080005);
        idle_drain(3);

        // Streaming pc 0..7 with a 1-cycle memory.
        dlv_pc.delete(); dlv_data.delete(); dlv_cyc.delete();
        next_pc = 32'h0; lat = 1; c0 = cyc;
        for (int i = 0; i < 14; i++) begin
            pc_valid = (next_pc < 8);
            step();
        end
        check("stream_count", dlv_pc.size(), 8);
        if (dlv_pc.size() == 8) begin
            check("stream_first_latency", dlv_cyc[0] - c0, 2);
            for (int i = 0; i < 8; i++) begin
                check("stream_pc", dlv_pc[i], i);
                check("stream_cycle", dlv_cyc[i] - c0, i + 2);
            end
        end
        idle_drain(3);

        // Full buffer with decode stalled.
        inst_ready = 1'b0; pc_valid = 1'b1; next_pc = 32'h20; base = issued;
        repeat (8) step();
        check("full_accepted", issued - base, 4);
        inst_ready = 1'b1; step();
        inst_ready = 1'b0; repeat (4) step();
        check("full_reissue", issued - base, 5);
        idle_drain(8);

        // Flush with reads in flight, memory latency 4.
        lat = 4; inst_ready = 1'b0; next_pc = 32'h100;
        pc_valid = 1'b1; step();
        pc_valid = 1'b0; repeat (3) step();
        pc_valid = 1'b1; repeat (2) step();
        pc_valid = 1'b0; flush = 1'b1; step();
        check("flush_drop_cnt", drop, 2);
        flush = 1'b0; inst_ready = 1'b1; next_pc = 32'h40;
        base = dlv_pc.size();
        pc_valid = 1'b1; step();
        pc_valid = 1'b0;
        wait_deliver(base + 1, 12);
        check("post_flush_pc", dlv_pc.size() > base ? dlv_pc[base] : 32'hFFFF_FFFF, 32'h40);
        check("post_flush_data", dlv_data.size() > base ? dlv_data[base] : 32'hFFFF_FFFF, mem_word(32'h40));
        idle_drain(6);
        check("post_flush_single", dlv_pc.size() - base, 1);

        // Flush coinciding with a response and an issue attempt.
        lat = 2; inst_ready = 1'b0; next_pc = 32'h200;
        pc_valid = 1'b1; repeat (3) step();
        flush = 1'b1; step();
        check("coinc_resp_seen", {31'h0, last_rv}, 32'h1);
        check("coinc_no_issue", {31'h0, last_mrv}, 32'h0);
        check("coinc_drop_cnt", drop, 1);
        flush = 1'b0;
        idle_drain(6);
        check("coinc_drop_drained", drop, 0);

        // Ten fetches with random decode stalls, forcing pointer wrap.
        dlv_pc.delete(); dlv_data.delete(); dlv_cyc.delete();
        next_pc = 32'h300;
        for (int i = 0; i < 80 && dlv_pc.size() < 10; i++) begin
            lat = 1 + int'($urandom_range(0, 2));
            pc_valid = (next_pc < 32'h30A);
            mem_bus.mem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 1) != 0);
            step();
        end
        check("wrap_count", dlv_pc.size(), 10);
        foreach (dlv_pc[i]) begin
            check("wrap_pc", dlv_pc[i], 32'h300 + i);
            check("wrap_data", dlv_data[i], mem_word(32'h300 + i));
        end
        idle_drain(6);

        // Long random run including flushes.
        dlv_pc.delete(); dlv_data.delete(); dlv_cyc.delete();
        for (int i = 0; i < 800; i++) begin
            lat = 1 + int'($urandom_range(0, 3));
            pc_valid = ($urandom_range(0, 3) != 0);
            mem_bus.mem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 24) == 0);
            if (flush) next_pc = $urandom & 32'h000F_FFF0;
            step();
        end
        flush = 1'b0;
        idle_drain(10);
        check("random_progress", {31'h0, dlv_pc.size() >= 100}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
